// File: rtl/shared_array_arbiter.sv
// Two-port arbiter/sequencer in front of a shared single-port register array.
// Ports: clk, reset, per-port req/we/addr/wdata in, ack/rdata out; macro ARB_RR_EN.
//
// shared_array_arbiter
// --------------------
// Purpose:
//   Serializes read/write accesses from two independent requesters onto an
//   internal WIDTH x DEPTH register array. One access is in flight at a
//   time: IDLE picks a winner and latches its request, BUSY performs the
//   array access and registers a one-cycle ack for the winner.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   reqN           port N request level, held until ackN
//   weN            port N: 1 = write, 0 = read
//   addrN [AW]     port N entry address
//   wdataN [WIDTH] port N write data
//   ackN           port N one-cycle completion pulse
//   rdataN [WIDTH] port N read data, valid with ackN after a read
//
// Configuration:
//   ARB_RR_EN  defined     -> round-robin tie-break with last-grant pointer
//              not defined -> fixed priority, port 0 wins every tie
//
// The array contents are not cleared by reset.

module shared_array_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    output logic [WIDTH-1:0] rdata0,

    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata1
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DEPTH != (1 << AW)) begin : g_bad_params
        $error("shared_array_arbiter: DEPTH must equal 2**AW");
    end

    // ------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Latched winning request (0 = port 0, 1 = port 1)
    logic             r_win;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_wdata;

    logic             r_ack0;
    logic             r_ack1;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;

    // ------------------------------------------------------------------
    // Eligibility and winner selection
    // ------------------------------------------------------------------
    // A port whose ack is currently high has not yet had a chance to drop
    // its request, so it is masked for this cycle.
    logic w_elig0;
    logic w_elig1;
    logic w_any;
    logic w_win;

    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    assign w_any   = w_elig0 | w_elig1;

`ifdef ARB_RR_EN
    // Last-grant pointer: on a tie the port not granted last wins.
    logic r_last;

    assign w_win = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
`else
    // Fixed priority: port 0 wins whenever it is eligible.
    assign w_win = ~w_elig0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    logic w_latch;   // capture the winner's request this cycle
    logic w_access;  // perform the latched access this cycle

    always_comb begin
        w_latch  = 1'b0;
        w_access = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_latch = w_any;
            end
            S_BUSY: begin
                w_access = 1'b1;
            end
            default: begin
                w_latch  = 1'b0;
                w_access = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant pointer
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_latch) begin
            r_last <= w_win;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    // Only the winner's inputs are sampled; the loser's are ignored
    // until it is granted in a later IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_win <= w_win;
            if (w_win) begin
                r_we    <= we1;
                r_addr  <= addr1;
                r_wdata <= wdata1;
            end else begin
                r_we    <= we0;
                r_addr  <= addr0;
                r_wdata <= wdata0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write
    // ------------------------------------------------------------------
    // Reset during BUSY aborts the access, so the write is gated by it.
    always_ff @(posedge clk) begin
        if (!reset && w_access && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Completion: ack pulse and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= w_access & ~r_win;
            r_ack1 <= w_access &  r_win;
            if (w_access && !r_we && !r_win) begin
                r_rdata0 <= r_mem[r_addr];
            end
            if (w_access && !r_we && r_win) begin
                r_rdata1 <= r_mem[r_addr];
            end
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
